// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, no-write-allocate data cache.
// Loads that hit answer in the same cycle; misses and all stores go through a
// registered memory handshake while the core is stalled.
module set_assoc_cache #(
    parameter int unsigned width     = 32,
    parameter int unsigned sets      = 4,
    parameter int unsigned ways      = 2,
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cache_enable_i,
    input  logic                 write_enable_i,
    input  logic                 byte_op_i,
    input  logic [width-1:0]     address_i,
    input  logic [width-1:0]     write_data_i,
    input  logic                 flush_i,
    output logic [width-1:0]     read_data_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_enable_o,
    output logic                 mem_byte_op_o,
    output logic [width-1:0]     mem_address_o,
    output logic [width-1:0]     mem_write_data_o,
    input  logic                 mem_ack_i,
    input  logic [width-1:0]     mem_incoming_data_i,
    output logic [cnt_width-1:0] hit_count_o,
    output logic [cnt_width-1:0] miss_count_o
);

    localparam int unsigned IDX_W = $clog2(sets);
    localparam int unsigned TAG_W = width - 2 - IDX_W;
    // Way index / round-robin pointer width; a single-way cache keeps a 1-bit field pinned at 0.
    localparam int unsigned PTR_W = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Line storage
    logic [ways-1:0]  valid_q [sets];
    logic [TAG_W-1:0] tag_q   [sets][ways];
    logic [width-1:0] data_q  [sets][ways];
    logic [PTR_W-1:0] ptr_q   [sets];

    // Request captured on entry to MEM
    logic             mem_req_q;
    logic             mem_we_q;
    logic             mem_byte_q;
    logic [width-1:0] mem_addr_q;
    logic [width-1:0] mem_wdata_q;
    logic             byte_q;
    logic [1:0]       off_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_cap_q;
    logic [width-1:0] resp_q;

    logic [cnt_width-1:0] hit_cnt_q;
    logic [cnt_width-1:0] miss_cnt_q;

    // Live request decode
    logic [1:0]       off_c;
    logic [IDX_W-1:0] idx_c;
    logic [TAG_W-1:0] tag_c;
    logic             hit_c;
    logic [PTR_W-1:0] hit_way_c;
    logic [PTR_W-1:0] victim_c;
    logic [PTR_W-1:0] ptr_adv_c;

    // FSM decisions
    logic             stall_c;
    logic [width-1:0] rdata_c;
    logic             capture_c;
    logic             fill_c;
    logic             flush_c;
    logic             store_hit_c;
    logic             hit_inc_c;
    logic             miss_inc_c;

    // Byte lane select with zero extension, or pass the word through.
    function automatic logic [width-1:0] lane_sel(input logic [width-1:0] w,
                                                  input logic [1:0]       off,
                                                  input logic             b);
        logic [7:0] by;
        by = w[{off, 3'b000} +: 8];
        return b ? width'(by) : w;
    endfunction

    // Merge store data into an existing word: one lane for bytes, all lanes for words.
    function automatic logic [width-1:0] lane_merge(input logic [width-1:0] old,
                                                    input logic [width-1:0] wd,
                                                    input logic [1:0]       off,
                                                    input logic             b);
        logic [width-1:0] r;
        r = old;
        if (b) r[{off, 3'b000} +: 8] = wd[7:0];
        else   r = wd;
        return r;
    endfunction

    assign off_c = address_i[1:0];
    assign idx_c = address_i[2 +: IDX_W];
    assign tag_c = address_i[width-1 -: TAG_W];

    // Tag lookup in the addressed set; at most one way matches.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < int'(ways); w++) begin
            if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = PTR_W'(w);
            end
        end
    end

    // Refill victim: lowest invalid way, otherwise the round-robin pointer.
    always_comb begin
        victim_c  = ptr_q[idx_q];
        for (int w = int'(ways) - 1; w >= 0; w--) begin
            if (!valid_q[idx_q][w]) victim_c = PTR_W'(w);
        end
        ptr_adv_c = (ptr_q[idx_q] == PTR_W'(ways - 1)) ? '0 : ptr_q[idx_q] + PTR_W'(1);
    end

    // Next state and per-cycle control decisions.
    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        rdata_c     = '0;
        capture_c   = 1'b0;
        fill_c      = 1'b0;
        flush_c     = 1'b0;
        store_hit_c = 1'b0;
        hit_inc_c   = 1'b0;
        miss_inc_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    // Flush wins; a concurrent request is held and retried next cycle.
                    flush_c = 1'b1;
                    stall_c = cache_enable_i;
                end else if (cache_enable_i) begin
                    if (write_enable_i) begin
                        stall_c     = 1'b1;
                        capture_c   = 1'b1;
                        store_hit_c = hit_c;
                        state_d     = MEM;
                    end else if (hit_c) begin
                        rdata_c   = lane_sel(data_q[idx_c][hit_way_c], off_c, byte_op_i);
                        hit_inc_c = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        capture_c  = 1'b1;
                        miss_inc_c = 1'b1;
                        state_d    = MEM;
                    end
                end
            end
            MEM: begin
                stall_c = 1'b1;
                if (mem_ack_i) begin
                    fill_c  = !mem_we_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_we_q) rdata_c = lane_sel(resp_q, off_q, byte_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, memory-side request registers and performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            byte_q      <= 1'b0;
            off_q       <= '0;
            idx_q       <= '0;
            tag_cap_q   <= '0;
            resp_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture_c) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= write_enable_i;
                mem_byte_q  <= write_enable_i & byte_op_i;
                mem_addr_q  <= write_enable_i ? address_i : {address_i[width-1:2], 2'b00};
                mem_wdata_q <= write_data_i;
                byte_q      <= byte_op_i;
                off_q       <= off_c;
                idx_q       <= idx_c;
                tag_cap_q   <= tag_c;
            end
            if ((state_q == MEM) && mem_ack_i) begin
                mem_req_q <= 1'b0;
                if (!mem_we_q) resp_q <= mem_incoming_data_i;
            end
            if (hit_inc_c && (hit_cnt_q != {cnt_width{1'b1}}))
                hit_cnt_q <= hit_cnt_q + cnt_width'(1);
            if (miss_inc_c && (miss_cnt_q != {cnt_width{1'b1}}))
                miss_cnt_q <= miss_cnt_q + cnt_width'(1);
        end
    end

    // Valid bits and replacement pointers; cleared by reset and flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(sets); s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (flush_c) begin
            for (int s = 0; s < int'(sets); s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (fill_c) begin
            valid_q[idx_q][victim_c] <= 1'b1;
            if (victim_c == ptr_q[idx_q]) ptr_q[idx_q] <= ptr_adv_c;
        end
    end

    // Tag and data arrays: refill on load ack, write-through update on store hit.
    always_ff @(posedge clk_i) begin
        if (fill_c) begin
            tag_q[idx_q][victim_c]  <= tag_cap_q;
            data_q[idx_q][victim_c] <= mem_incoming_data_i;
        end else if (store_hit_c) begin
            data_q[idx_c][hit_way_c] <= lane_merge(data_q[idx_c][hit_way_c], write_data_i,
                                                   off_c, byte_op_i);
        end
    end

    // Core-side outputs are forced quiet while reset is asserted.
    assign stall_o            = rst_ni & stall_c;
    assign read_data_o        = rst_ni ? rdata_c : '0;
    assign mem_req_o          = mem_req_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_byte_op_o      = mem_byte_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_write_data_o   = mem_wdata_q;
    assign hit_count_o        = hit_cnt_q;
    assign miss_count_o       = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural cache/memory model.
module tb_set_assoc_cache;

    localparam int unsigned W    = 32;
    localparam int unsigned SETS = 4;
    localparam int unsigned WAYS = 2;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_ni;
    logic          cache_enable_i;
    logic          write_enable_i;
    logic          byte_op_i;
    logic [W-1:0]  address_i;
    logic [W-1:0]  write_data_i;
    logic          flush_i;
    logic [W-1:0]  read_data_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_write_enable_o;
    logic          mem_byte_op_o;
    logic [W-1:0]  mem_address_o;
    logic [W-1:0]  mem_write_data_o;
    logic          mem_ack_i;
    logic [W-1:0]  mem_incoming_data_i;
    logic [CW-1:0] hit_count_o;
    logic [CW-1:0] miss_count_o;

    set_assoc_cache #(
        .width(W), .sets(SETS), .ways(WAYS), .cnt_width(CW)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .cache_enable_i      (cache_enable_i),
        .write_enable_i      (write_enable_i),
        .byte_op_i           (byte_op_i),
        .address_i           (address_i),
        .write_data_i        (write_data_i),
        .flush_i             (flush_i),
        .read_data_o         (read_data_o),
        .stall_o             (stall_o),
        .mem_req_o           (mem_req_o),
        .mem_write_enable_o  (mem_write_enable_o),
        .mem_byte_op_o       (mem_byte_op_o),
        .mem_address_o       (mem_address_o),
        .mem_write_data_o    (mem_write_data_o),
        .mem_ack_i           (mem_ack_i),
        .mem_incoming_data_i (mem_incoming_data_i),
        .hit_count_o         (hit_count_o),
        .miss_count_o        (miss_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- memories: golden (model) and responder (DUT-facing) ----------------
    logic [31:0] gmem [int unsigned];
    logic [31:0] rmem [int unsigned];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE0000 | {16'h0000, a[15:2], 2'b00};
    endfunction

    function automatic logic [31:0] gread(input logic [31:0] a);
        int unsigned k = a >> 2;
        return gmem.exists(k) ? gmem[k] : pat(a);
    endfunction

    function automatic logic [31:0] rread(input logic [31:0] a);
        int unsigned k = a >> 2;
        return rmem.exists(k) ? rmem[k] : pat(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] a, input bit b);
        logic [31:0] r;
        int off;
        r   = old;
        off = int'(a[1:0]);
        if (b) r[8*off +: 8] = d[7:0];
        else   r = d;
        return r;
    endfunction

    // ---------------- memory responder ----------------
    int ack_delay = 3;
    bit hold      = 1'b0;
    int wait_cnt  = 0;
    int wr_count  = 0;

    always @(negedge clk) begin
        mem_ack_i           = 1'b0;
        mem_incoming_data_i = $urandom;
        if (mem_req_o && !hold) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack_i = 1'b1;
                wait_cnt  = 0;
                if (mem_write_enable_o) begin
                    rmem[mem_address_o >> 2] = merge(rread(mem_address_o), mem_write_data_o,
                                                     mem_address_o, mem_byte_op_o);
                    wr_count++;
                end else begin
                    mem_incoming_data_i = rread(mem_address_o);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- behavioural cache model ----------------
    bit rv   [SETS][WAYS];
    int rt   [SETS][WAYS];
    int rptr [SETS];
    int ref_hits = 0;
    int ref_miss = 0;

    task automatic ref_flush();
        for (int s = 0; s < int'(SETS); s++) begin
            rptr[s] = 0;
            for (int w = 0; w < int'(WAYS); w++) rv[s][w] = 1'b0;
        end
    endtask

    // Returns whether the access completes without stalling and the load value.
    task automatic ref_access(input bit we, input bit bt, input logic [31:0] addr,
                              input logic [31:0] wd, output bit hit, output logic [31:0] data);
        int s;
        int t;
        int v;
        s    = int'((addr >> 2) % SETS);
        t    = int'(addr / (4 * SETS));
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < int'(WAYS); w++) if (rv[s][w] && rt[s][w] == t) hit = 1'b1;
        if (we) begin
            gmem[addr >> 2] = merge(gread(addr), wd, addr, bt);
            hit = 1'b0;
            return;
        end
        if (hit) begin
            if (ref_hits < CMAX) ref_hits++;
        end else begin
            if (ref_miss < CMAX) ref_miss++;
            v = -1;
            for (int w = 0; w < int'(WAYS); w++) if (v < 0 && !rv[s][w]) v = w;
            if (v < 0) v = rptr[s];
            if (v == rptr[s]) rptr[s] = (rptr[s] + 1) % int'(WAYS);
            rv[s][v] = 1'b1;
            rt[s][v] = t;
        end
        data = gread(addr);
        if (bt) data = (data >> (8 * int'(addr[1:0]))) & 32'hFF;
    endtask

    // ---------------- access driver (starts and ends on a falling edge) ----------------
    task automatic do_access(input bit we, input bit bt, input logic [31:0] addr,
                             input logic [31:0] wd, input bit exp_hit, input bit chk_data,
                             input logic [31:0] exp_data);
        logic [31:0] got;
        bit          stalled;
        bit          done;
        bit          seen;
        int          wr0;
        logic [31:0] m_addr;
        logic [31:0] m_wd;
        logic        m_we;
        logic        m_b;
        wr0    = wr_count;
        seen   = 1'b0;
        done   = 1'b0;
        got    = '0;
        m_addr = '0;
        m_wd   = '0;
        m_we   = 1'b0;
        m_b    = 1'b0;
        cache_enable_i = 1'b1;
        write_enable_i = we;
        byte_op_i      = bt;
        address_i      = addr;
        write_data_i   = wd;
        #1;
        stalled = stall_o;
        if (!stalled) begin
            got  = read_data_o;
            done = 1'b1;
        end else begin
            for (int n = 0; n < 200 && !done; n++) begin
                @(negedge clk);
                #1;
                if (mem_req_o && !seen) begin
                    seen   = 1'b1;
                    m_addr = mem_address_o;
                    m_we   = mem_write_enable_o;
                    m_b    = mem_byte_op_o;
                    m_wd   = mem_write_data_o;
                end
                if (!stall_o) begin
                    done = 1'b1;
                    got  = read_data_o;
                end
            end
            chk("completion", 32'(done), 32'd1);
        end
        chk("hit", 32'(!stalled), 32'(exp_hit));
        if (!we && chk_data) chk("rdata", got, exp_data);
        if (stalled) begin
            chk("mem_addr", m_addr, we ? addr : {addr[31:2], 2'b00});
            chk("mem_we", 32'(m_we), 32'(we));
            chk("mem_byte", 32'(m_b), 32'(we & bt));
            if (we) chk("mem_wdata", bt ? {24'h0, m_wd[7:0]} : m_wd, bt ? {24'h0, wd[7:0]} : wd);
            chk("mem_writes", 32'(wr_count - wr0), we ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        cache_enable_i = 1'b0;
        chk("hit_count", 32'(hit_count_o), 32'(ref_hits));
        chk("miss_count", 32'(miss_count_o), 32'(ref_miss));
    endtask

    task automatic run_ref(input bit we, input bit bt, input logic [31:0] addr,
                           input logic [31:0] wd);
        bit          h;
        logic [31:0] d;
        ref_access(we, bt, addr, wd, h, d);
        do_access(we, bt, addr, wd, h, !we, d);
    endtask

    task automatic do_flush();
        cache_enable_i = 1'b0;
        flush_i        = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        ref_flush();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          op;    // 0 load, 1 store, 2 flush
        bit          bt;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          eh;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          h;
        logic [31:0] d;
        bit          done;

        rst_ni         = 1'b0;
        cache_enable_i = 1'b0;
        write_enable_i = 1'b0;
        byte_op_i      = 1'b0;
        address_i      = '0;
        write_data_i   = '0;
        flush_i        = 1'b0;
        mem_ack_i      = 1'b0;
        mem_incoming_data_i = '0;
        gmem[32'h100 >> 2] = 32'hDEADBEEF;
        rmem[32'h100 >> 2] = 32'hDEADBEEF;
        ref_flush();

        tbl.push_back('{0, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF});
        tbl.push_back('{0, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF});
        tbl.push_back('{1, 1'b1, 32'h101, 32'h000000AB, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b1, 32'h101, 32'h0,        1'b1, 32'h000000AB});
        tbl.push_back('{0, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADABEF});
        tbl.push_back('{2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h000, 32'h0,        1'b0, 32'hC0DE0000});
        tbl.push_back('{0, 1'b0, 32'h010, 32'h0,        1'b0, 32'hC0DE0010});
        tbl.push_back('{0, 1'b0, 32'h020, 32'h0,        1'b0, 32'hC0DE0020});
        tbl.push_back('{0, 1'b0, 32'h010, 32'h0,        1'b1, 32'hC0DE0010});
        tbl.push_back('{0, 1'b0, 32'h000, 32'h0,        1'b0, 32'hC0DE0000});
        tbl.push_back('{1, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h200, 32'h0,        1'b0, 32'h12345678});
        tbl.push_back('{2, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0});
        tbl.push_back('{0, 1'b0, 32'h000, 32'h0,        1'b0, 32'hC0DE0000});
        tbl.push_back('{0, 1'b0, 32'h200, 32'h0,        1'b0, 32'h12345678});
        tbl.push_back('{0, 1'b1, 32'h203, 32'h0,        1'b1, 32'h00000012});

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_write_enable_o), 32'd0);
        chk("rst_mem_byte", 32'(mem_byte_op_o), 32'd0);
        chk("rst_mem_addr", mem_address_o, 32'd0);
        chk("rst_mem_wdata", mem_write_data_o, 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);
        chk("rst_hit_cnt", 32'(hit_count_o), 32'd0);
        chk("rst_miss_cnt", 32'(miss_count_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Directed vectors
        ack_delay = 3;
        foreach (tbl[i]) begin
            if (tbl[i].op == 2) begin
                do_flush();
            end else begin
                ref_access(tbl[i].op == 1, tbl[i].bt, tbl[i].addr, tbl[i].wd, h, d);
                do_access(tbl[i].op == 1, tbl[i].bt, tbl[i].addr, tbl[i].wd,
                          tbl[i].eh, 1'b1, tbl[i].ed);
            end
        end

        // Flush and request together: flush wins, request misses afterwards
        cache_enable_i = 1'b1;
        write_enable_i = 1'b0;
        byte_op_i      = 1'b0;
        address_i      = 32'h200;
        flush_i        = 1'b1;
        #1;
        chk("flush_req_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        ref_flush();
        run_ref(1'b0, 1'b0, 32'h200, 32'h0);

        // Flush while in MEM is ignored; the refill lands
        ref_access(1'b0, 1'b0, 32'h040, 32'h0, h, d);
        ack_delay      = 4;
        cache_enable_i = 1'b1;
        write_enable_i = 1'b0;
        byte_op_i      = 1'b0;
        address_i      = 32'h040;
        #1;
        chk("fmem_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        #1;
        chk("fmem_req", 32'(mem_req_o), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        done    = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (!stall_o) done = 1'b1;
            else @(negedge clk);
        end
        chk("fmem_done", 32'(done), 32'd1);
        chk("fmem_rdata", read_data_o, d);
        @(negedge clk);
        cache_enable_i = 1'b0;
        run_ref(1'b0, 1'b0, 32'h040, 32'h0);

        // Reset in the middle of a memory transaction
        hold           = 1'b1;
        cache_enable_i = 1'b1;
        write_enable_i = 1'b0;
        byte_op_i      = 1'b0;
        address_i      = 32'h340;
        #1;
        chk("rmem_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        #1;
        chk("rmem_req", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rmem_req_drop", 32'(mem_req_o), 32'd0);
        chk("rmem_stall_drop", 32'(stall_o), 32'd0);
        chk("rmem_hit_cnt", 32'(hit_count_o), 32'd0);
        chk("rmem_miss_cnt", 32'(miss_count_o), 32'd0);
        @(negedge clk);
        rst_ni         = 1'b1;
        hold           = 1'b0;
        cache_enable_i = 1'b0;
        ref_flush();
        ref_hits = 0;
        ref_miss = 0;
        @(negedge clk);
        run_ref(1'b0, 1'b0, 32'h340, 32'h0);

        // Random traffic over a small address pool so sets see hits and evictions
        for (int i = 0; i < 300; i++) begin
            int          r;
            bit          we;
            bit          bt;
            logic [31:0] a;
            r  = int'($urandom_range(0, 99));
            we = (r < 35);
            bt = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 5)) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
            if (bt) a = a + 32'($urandom_range(0, 3));
            ack_delay = int'($urandom_range(0, 3));
            if (r >= 95) do_flush();
            else run_ref(we, bt, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
